control_index_decoder: RTL
==========================

Name: control_index_decoder

Overview:
- Receive side of the 8-bit one-hot control word that the M/m control generator produces from two 3-bit operands.
- Accepts control words over a valid/ready handshake, checks that each is legal one-hot, and encodes it back to the 3-bit index (max of M, m).
- Buffers results in a small FIFO and presents them downstream with a valid/ready handshake.
- Sits between the control-word producer and the datapath/display logic that consumes index values.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- AW, 2, FIFO pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_control is valid this cycle.
- in_ready  output  1  block can accept a word this cycle.
- in_control  input  8  control word, nominally one-hot.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer accepts the head this cycle.
- out_index  output  3  decoded index of the FIFO head.
- out_err  output  1  FIFO head came from an illegal control word.
- count  output  AW+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (reset=1 at a rising clk edge):
  - Read/write pointers and count go to 0.
  - out_valid=0, out_index=0, out_err=0, in_ready=1 from the next cycle.
  - Reset has priority over any handshake in the same cycle. A word offered in a reset cycle is dropped, and a head being popped is discarded.
- Handshakes:
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = (count != DEPTH). It is combinational from registered count only and does not depend on out_ready, so a full FIFO refuses input even if a pop happens in the same cycle.
  - out_valid = (count != 0).
- Decode is combinational on in_control and written into the FIFO at push. Each entry holds {err, index[2:0]}.
  - Exactly one bit k set: index=k, err=0.
  - Zero bits set: index=0, err=1.
  - Two or more bits set: index = position of the highest set bit, err=1.
- Latency: a word pushed at edge N is visible on out_* after edge N (one cycle). There is no combinational in->out path.
- out_index and out_err are driven from the FIFO head. When count==0 they hold the last popped value; they are meaningful only when out_valid=1.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together (possible only when 0<count<DEPTH): unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Order is strict FIFO. The block never drops or duplicates accepted words.
- Boundaries:
  - Empty: out_ready is ignored.
  - Full: in_valid is ignored and in_control is not sampled.
  - Empty with push in the same cycle: no bypass; the word appears the next cycle.

Optional Feature:
- Macro: CONTROL_INDEX_ERRCNT_EN.
- When defined:
  - Adds output port err_count (8 bits).
  - Counts accepted words decoded with err=1; saturates at 255.
  - Cleared by reset only.
  - Increments at the push edge, not the pop edge.
- When undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then push 8'h01, 8'h04, 8'h80 back-to-back with out_ready=1 -> out_index 0, 2, 7 on consecutive cycles starting one cycle after the first push; out_err=0; count never exceeds 1.
- out_ready=0, push 5 words with DEPTH=4 -> in_ready drops after the 4th accept and count=4. Raise out_ready -> 4 words out in order; the 5th is accepted on the first cycle that count<4.
- Push 8'h00 then 8'h28 -> outputs {err=1, index=0} then {err=1, index=5}. With CONTROL_INDEX_ERRCNT_EN, err_count=2.
- count=2, in_valid=1 and out_ready=1 held for 10 cycles with a walking one-hot pattern -> count stays 2 and output order matches input order.
- Assert reset mid-stream with count=3 and in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1; no stale data appears after reset.
- Errcnt build: push 300 words of 8'hFF -> err_count saturates at 255.

Source files
------------

// File: rtl/control_index_decoder_if.sv
// Handshake bundle between the control-word producer, the index decoder and its consumer.
// With CONTROL_INDEX_ERRCNT_EN defined the bundle also carries the saturating error counter.
interface control_index_decoder_if #(
    parameter int AW = 2
);
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_control;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    out_index;
    logic          out_err;
    logic [AW:0]   count;
`ifdef CONTROL_INDEX_ERRCNT_EN
    logic [7:0]    err_count;
`endif

    modport slave (
`ifdef CONTROL_INDEX_ERRCNT_EN
        output err_count,
`endif
        input  in_valid,
        input  in_control,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_index,
        output out_err,
        output count
    );

    modport master (
`ifdef CONTROL_INDEX_ERRCNT_EN
        input  err_count,
`endif
        output in_valid,
        output in_control,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_index,
        input  out_err,
        input  count
    );
endinterface

// File: rtl/control_index_decoder.sv
// Decodes one-hot control words to a 3-bit index (flagging illegal words) and queues them in a FIFO.
// Optional macro CONTROL_INDEX_ERRCNT_EN adds a saturating count of illegal words accepted.
module control_index_decoder #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    control_index_decoder_if.slave bus
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    // Entry layout is {err, index[2:0]}; the highest set bit wins when several are set.
    function automatic logic [3:0] decode_ctrl(input logic [7:0] c);
        logic [2:0] idx;
        logic       err;
        idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (c[k]) idx = 3'(k);
        end
        err = (c == 8'd0) || ((c & (c - 8'd1)) != 8'd0);
        return {err, idx};
    endfunction

    logic [3:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [3:0]    r_head;

    logic          w_push;
    logic          w_pop;
    logic [3:0]    w_dec;
    logic [AW-1:0] w_rptr_nxt;
    logic [AW:0]   w_count_nxt;

    assign bus.in_ready  = (r_count != FULL);
    assign bus.out_valid = (r_count != '0);
    assign bus.out_index = r_head[2:0];
    assign bus.out_err   = r_head[3];
    assign bus.count     = r_count;

    assign w_push     = bus.in_valid && bus.in_ready;
    assign w_pop      = bus.out_valid && bus.out_ready;
    assign w_dec      = decode_ctrl(bus.in_control);
    assign w_rptr_nxt = w_pop ? r_rptr + AW'(1) : r_rptr;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (AW+1)'(1);
            2'b01:   w_count_nxt = r_count - (AW+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push && !reset) r_mem[r_wptr] <= w_dec;
    end

    // The head is registered so it holds the last popped entry once the FIFO drains;
    // when the next head is the word being written this edge it is taken from the decoder.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_head  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            if (w_count_nxt != '0) begin
                r_head <= (w_push && (r_wptr == w_rptr_nxt)) ? w_dec : r_mem[w_rptr_nxt];
            end
        end
    end

`ifdef CONTROL_INDEX_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_cnt <= 8'd0;
        end else if (w_push && w_dec[3] && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign bus.err_count = r_err_cnt;
`endif
endmodule
